arbitro_rr8: RTL and testbench

ARBITRO_RR8 -- requirements
Module: arbitro_rr8

---
 rtl/arbitro_rr8.sv | 136 +++++++++++++
 tb/tb_arbitro_rr8.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/arbitro_rr8.sv
// arbitro_rr8: 8-way arbiter, fixed priority or round-robin, with a hold limit.
// Ports: clk, reset (sync, active low), req[7:0], modo (0 fixed, 1 rr);
//   gnt[7:0] one-hot grant, gnt_id grant index, ocupado busy, timeout pulse.
module arbitro_rr8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       modo,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       ocupado,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_id_q, gnt_id_d;
  logic       ocupado_q, ocupado_d;
  logic       timeout_q, timeout_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] ptr_q, ptr_d;

  logic [2:0] fp_win;
  logic [2:0] rr_win;
  logic [2:0] idx;
  logic       rr_found;
  logic [2:0] win;
  logic       any_req;
  logic       hold_max;

  // Fixed priority: later (higher) indices overwrite, so req[7] wins.
  // Round-robin: walk down from ptr with 3-bit wrap, first hit wins.
  always_comb begin
    fp_win   = 3'd0;
    rr_win   = 3'd0;
    rr_found = 1'b0;
    idx      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) fp_win = 3'(i);
    end
    for (int k = 0; k < 8; k++) begin
      idx = ptr_q - 3'(k);
      if (!rr_found && req[idx]) begin
        rr_win   = idx;
        rr_found = 1'b1;
      end
    end
    win      = modo ? rr_win : fp_win;
    any_req  = |req;
    hold_max = (cnt_q == 8'(MAX_HOLD));
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ocupado_d = ocupado_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    unique case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_d   = GRANT;
          gnt_d     = 8'd1 << win;
          gnt_id_d  = win;
          ocupado_d = 1'b1;
          cnt_d     = 8'd1;
          ptr_d     = win - 3'd1;
        end else begin
          state_d   = IDLE;
          gnt_d     = 8'h00;
          ocupado_d = 1'b0;
          cnt_d     = 8'd0;
        end
      end
      GRANT: begin
        // Release has precedence over the hold limit: no timeout then.
        if (!req[gnt_id_q]) begin
          state_d   = GAP;
          gnt_d     = 8'h00;
          ocupado_d = 1'b0;
          cnt_d     = 8'd0;
        end else if (hold_max) begin
          state_d   = GAP;
          gnt_d     = 8'h00;
          ocupado_d = 1'b0;
          timeout_d = 1'b1;
          cnt_d     = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = 8'h00;
        ocupado_d = 1'b0;
        cnt_d     = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      gnt_q     <= 8'h00;
      gnt_id_q  <= 3'd0;
      ocupado_q <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= 8'd0;
      ptr_q     <= 3'd7;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ocupado_q <= ocupado_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign ocupado = ocupado_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_arbitro_rr8.sv
// tb_arbitro_rr8: directed vectors with a queue scoreboard.
// Three instances (MAX_HOLD 16, 2, 4) share inputs; each entry selects one.
module tb_arbitro_rr8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       modo = 1'b0;

  logic [7:0] g_a [3];
  logic [2:0] id_a [3];
  logic       oc_a [3];
  logic       to_a [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         sel;
    logic [7:0] g;
    logic [2:0] id;
    logic       oc;
    logic       to;
    string      nm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  arbitro_rr8 #(.MAX_HOLD(16)) u_h16 (
    .clk(clk), .reset(rst_n), .req(req), .modo(modo),
    .gnt(g_a[0]), .gnt_id(id_a[0]),
    .ocupado(oc_a[0]), .timeout(to_a[0])
  );

  arbitro_rr8 #(.MAX_HOLD(2)) u_h2 (
    .clk(clk), .reset(rst_n), .req(req), .modo(modo),
    .gnt(g_a[1]), .gnt_id(id_a[1]),
    .ocupado(oc_a[1]), .timeout(to_a[1])
  );

  arbitro_rr8 #(.MAX_HOLD(4)) u_h4 (
    .clk(clk), .reset(rst_n), .req(req), .modo(modo),
    .gnt(g_a[2]), .gnt_id(id_a[2]),
    .ocupado(oc_a[2]), .timeout(to_a[2])
  );

  // Monitor: the entry pushed before an edge describes the outputs after it.
  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        ok = (g_a[e.sel] === e.g) && (oc_a[e.sel] === e.oc)
          && (to_a[e.sel] === e.to);
        if (e.oc && (id_a[e.sel] !== e.id)) ok = 1'b0;
        if (!ok) begin
          errors++;
          $display("FAIL %s: got gnt=%h id=%0d oc=%b to=%b want gnt=%h id=%0d oc=%b to=%b",
            e.nm, g_a[e.sel], id_a[e.sel], oc_a[e.sel], to_a[e.sel],
            e.g, e.id, e.oc, e.to);
        end
      end
    end
  end

  task automatic vec(input int s, input logic r, input logic [7:0] rq,
                     input logic m, input logic [7:0] g, input logic [2:0] id,
                     input logic oc, input logic to, input string nm);
    exp_t e;
    @(negedge clk);
    rst_n = r;
    req   = rq;
    modo  = m;
    e.sel = s; e.g = g; e.id = id; e.oc = oc; e.to = to; e.nm = nm;
    sb.push_back(e);
  endtask

  initial begin
    logic [2:0] k;

    // Reset state and idle behaviour.
    vec(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset0");
    vec(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "reset1");
    for (int i = 0; i < 20; i++)
      vec(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, "idle");

    // Fixed priority, other bits ignored during a grant, release + gap.
    vec(0, 1, 8'h26, 0, 8'h20, 5, 1, 0, "fp_win5");
    vec(0, 1, 8'hA6, 0, 8'h20, 5, 1, 0, "fp_ignore7");
    vec(0, 1, 8'h26, 0, 8'h20, 5, 1, 0, "fp_hold5");
    vec(0, 1, 8'h06, 0, 8'h00, 0, 0, 0, "fp_gap");
    vec(0, 1, 8'h06, 0, 8'h04, 2, 1, 0, "fp_win2");
    vec(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, "fp_rel");
    vec(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, "fp_idle");

    // Timeout and re-grant with MAX_HOLD=16.
    vec(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "to_reset");
    for (int i = 0; i < 16; i++)
      vec(0, 1, 8'h04, 0, 8'h04, 2, 1, 0, "to_hold");
    vec(0, 1, 8'h04, 0, 8'h00, 0, 0, 1, "to_gap");
    vec(0, 1, 8'h04, 0, 8'h04, 2, 1, 0, "to_regrant");
    vec(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, "to_rel");
    vec(0, 1, 8'h00, 0, 8'h00, 0, 0, 0, "to_idle");

    // Round-robin rotation, MAX_HOLD=2: 7,6,...,0,7.
    vec(1, 0, 8'h00, 1, 8'h00, 0, 0, 0, "rr_reset");
    k = 3'd7;
    for (int n = 0; n < 9; n++) begin
      vec(1, 1, 8'hFF, 1, 8'h01 << k, k, 1, 0, "rr_g1");
      vec(1, 1, 8'hFF, 1, 8'h01 << k, k, 1, 0, "rr_g2");
      vec(1, 1, 8'hFF, 1, 8'h00, 0, 0, 1, "rr_gap");
      k = k - 3'd1;
    end
    vec(1, 1, 8'h00, 1, 8'h00, 0, 0, 0, "rr_idle");

    // Release and limit on the same cycle, MAX_HOLD=4.
    vec(2, 0, 8'h00, 0, 8'h00, 0, 0, 0, "tie_reset");
    for (int i = 0; i < 4; i++)
      vec(2, 1, 8'h08, 0, 8'h08, 3, 1, 0, "tie_hold");
    vec(2, 1, 8'h00, 0, 8'h00, 0, 0, 0, "tie_gap");
    vec(2, 1, 8'h00, 0, 8'h00, 0, 0, 0, "tie_idle");

    // Reset mid-grant restores ptr=7.
    vec(0, 0, 8'h00, 0, 8'h00, 0, 0, 0, "mr_reset");
    vec(0, 1, 8'h40, 0, 8'h40, 6, 1, 0, "mr_g6");
    vec(0, 1, 8'h40, 0, 8'h40, 6, 1, 0, "mr_hold");
    vec(0, 0, 8'h40, 0, 8'h00, 0, 0, 0, "mr_revoke");
    vec(0, 1, 8'h00, 1, 8'h00, 0, 0, 0, "mr_idle");
    vec(0, 1, 8'h41, 1, 8'h40, 6, 1, 0, "mr_rr6");
    vec(0, 1, 8'h00, 1, 8'h00, 0, 0, 0, "mr_rel");
    vec(0, 1, 8'h00, 1, 8'h00, 0, 0, 0, "mr_end");

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
